// File: rtl/wssa_pkg.sv
// rtl/wssa_pkg.sv - shared state encoding, default geometry and watchdog constant
package wssa_pkg;

  localparam int DIM_DEF   = 8;
  localparam int DW_DEF    = 8;
  localparam int ACC_W_DEF = 16;
  localparam int WD_MULT   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADW,
    S_FEED,
    S_DRAIN,
    S_FIN
  } state_t;

  function automatic logic field_ok(input int unsigned f, input int unsigned dim);
    return (f != 0) && (f <= dim);
  endfunction

endpackage

// File: rtl/wssa_addr_cnt.sv
// rtl/wssa_addr_cnt.sv - address counter with clear, enable and last-of-limit flag
module wssa_addr_cnt #(
  parameter int AW = 3,
  parameter int LW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [LW-1:0] i_limit,
  output logic [AW-1:0] o_cnt,
  output logic          o_last
);

  logic [AW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  // compared at 32 bits so a limit equal to 2**AW is still reachable
  assign o_last = (32'(r_cnt) + 32'd1) == 32'(i_limit);

endmodule

// File: rtl/wssa_seq.sv
// rtl/wssa_seq.sv - weight-stationary systolic array job sequencer
// Optional cycle counter output o_cyc_cnt under WSSA_SEQ_PERF_EN.
module wssa_seq
  import wssa_pkg::*;
#(
  parameter int DIM   = DIM_DEF,
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int AW_I  = 3,
  parameter int AW_W  = 3,
  parameter int AW_O  = 4,
  localparam int CW   = $clog2(DIM + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [3*CW-1:0]      i_mnt,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_en_w,
  output logic [AW_W-1:0]      o_addr_w,
  output logic                 o_en_i,
  output logic [AW_I-1:0]      o_addr_i,
  output logic                 o_w_load,
  output logic                 o_i_valid,
  input  logic                 i_res_valid,
  input  logic [DIM*ACC_W-1:0] i_res_data,
  output logic                 o_en_o,
  output logic                 o_rw_o,
  output logic [AW_O-1:0]      o_addr_o,
  output logic [DIM*ACC_W-1:0] o_wdata_o
`ifdef WSSA_SEQ_PERF_EN
  ,
  output logic [15:0]          o_cyc_cnt
`endif
);

  localparam int WD_LIMIT = WD_MULT * DIM;
  localparam int WDW      = $clog2(WD_LIMIT + 1);

  if (DW < 1) begin : g_bad_cfg
    $error("wssa_seq: DW must be positive");
  end

  state_t r_state, w_next;

  logic [CW-1:0] w_m, w_n, w_t;
  logic [CW-1:0] r_m, r_t;
  logic          w_legal;
  logic          w_start_ok, w_start_bad, w_wd_trip;
  logic          w_clr_all;

  logic          r_busy, r_done, r_err;
  logic          r_w_load, r_i_valid;
  logic [WDW-1:0] r_wd;

  logic            w_w_last, w_i_last, w_o_last;
  logic [AW_O-1:0] w_o_cnt;
  logic            w_acc;
  logic            r_o_full;

  logic                 r_wr_v, r_wr_last;
  logic [AW_O-1:0]      r_wr_addr;
  logic [DIM*ACC_W-1:0] r_wr_data;

  assign w_m = i_mnt[3*CW-1 -: CW];
  assign w_n = i_mnt[2*CW-1 -: CW];
  assign w_t = i_mnt[CW-1:0];
  assign w_legal = field_ok(32'(w_m), DIM) && field_ok(32'(w_n), DIM) &&
                   field_ok(32'(w_t), DIM);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_wd_trip   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_legal) begin
            w_start_ok = 1'b1;
            w_next     = S_LOADW;
          end else begin
            w_start_bad = 1'b1;
            w_next      = S_FIN;
          end
        end
      end
      S_LOADW: if (w_w_last) w_next = S_FEED;
      S_FEED: begin
        if (r_wr_v && r_wr_last) w_next = S_FIN;
        else if (w_i_last)       w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_wr_v && r_wr_last) begin
          w_next = S_FIN;
        end else if (!i_res_valid && r_wd == WDW'(WD_LIMIT - 1)) begin
          w_wd_trip = 1'b1;
          w_next    = S_FIN;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_clr_all = w_start_ok | (r_state == S_FIN);
  assign o_en_w    = (r_state == S_LOADW);
  assign o_en_i    = (r_state == S_FEED);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_m       <= '0;
      r_t       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_w_load  <= 1'b0;
      r_i_valid <= 1'b0;
      r_wd      <= '0;
    end else begin
      r_w_load  <= o_en_w;
      r_i_valid <= o_en_i;
      r_done    <= (r_state == S_FIN);
      if (w_start_ok) begin
        r_m <= w_m;
        r_t <= w_t;
      end
      if (w_start_ok || w_start_bad) begin
        r_busy <= 1'b1;
        r_err  <= w_start_bad;
      end else if (w_wd_trip) begin
        r_err <= 1'b1;
      end else if (r_state == S_FIN) begin
        r_busy <= 1'b0;
      end
      // watchdog only runs while waiting for results after the feed
      if (r_state != S_DRAIN || i_res_valid) r_wd <= '0;
      else                                   r_wd <= r_wd + 1'b1;
    end
  end

  wssa_addr_cnt #(.AW(AW_W), .LW(CW)) u_cnt_w (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_clr_all | (o_en_w & w_w_last)),
    .i_en    (o_en_w),
    .i_limit (r_t),
    .o_cnt   (o_addr_w),
    .o_last  (w_w_last)
  );

  wssa_addr_cnt #(.AW(AW_I), .LW(CW)) u_cnt_i (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_clr_all | (o_en_i & w_i_last)),
    .i_en    (o_en_i),
    .i_limit (r_m),
    .o_cnt   (o_addr_i),
    .o_last  (w_i_last)
  );

  assign w_acc = i_res_valid && !r_o_full &&
                 ((r_state == S_FEED) || (r_state == S_DRAIN));

  wssa_addr_cnt #(.AW(AW_O), .LW(CW)) u_cnt_o (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_clr_all),
    .i_en    (w_acc),
    .i_limit (r_m),
    .o_cnt   (w_o_cnt),
    .o_last  (w_o_last)
  );

  // accepted results are registered and written one cycle later
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_o_full  <= 1'b0;
      r_wr_v    <= 1'b0;
      r_wr_last <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_clr_all)               r_o_full <= 1'b0;
      else if (w_acc && w_o_last)  r_o_full <= 1'b1;
      r_wr_v    <= w_acc;
      r_wr_last <= w_acc & w_o_last;
      r_wr_addr <= w_acc ? w_o_cnt : '0;
      if (w_acc) r_wr_data <= i_res_data;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_w_load  = r_w_load;
  assign o_i_valid = r_i_valid;
  assign o_en_o    = r_wr_v;
  assign o_rw_o    = r_wr_v;
  assign o_addr_o  = r_wr_addr;
  assign o_wdata_o = r_wr_data;

`ifdef WSSA_SEQ_PERF_EN
  logic [15:0] r_cyc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cyc <= '0;
    end else if (w_start_ok || w_start_bad) begin
      r_cyc <= '0;
    end else if (r_state != S_IDLE && r_cyc != 16'hFFFF) begin
      r_cyc <= r_cyc + 16'd1;
    end
  end

  assign o_cyc_cnt = r_cyc;
`endif

endmodule
